// File: rtl/usb_pkg.sv
// Shared types and sizing for the USB data buffer arbiter.
// Buffer geometry, arbiter states and access source/destination tags.
package usb_pkg;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RDATA,
    ST_FLUSH
  } arb_state_e;

  typedef enum logic [1:0] {
    SRC_RX,
    SRC_AHB,
    DST_TX,
    DST_AHB
  } sel_e;

endpackage

// File: rtl/usb_fifo_ptrs.sv
// Write/read pointers and occupancy of the shared buffer.
// Flags are registered alongside the count so they never lag it.
module usb_fifo_ptrs
  import usb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_wr_i,
  input  logic              inc_rd_i,
  input  logic              clear_i,
  output logic [ADDR_W-1:0] wr_ptr_o,
  output logic [ADDR_W-1:0] rd_ptr_o,
  output logic [ADDR_W:0]   count_o,
  output logic              empty_o,
  output logic              full_o
);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, full_q;
  logic              wr_en, rd_en;

  always_comb begin
    wr_en    = inc_wr_i && !full_q;
    rd_en    = inc_rd_i && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + (ADDR_W+1)'(1);
        2'b01:   count_d = count_q - (ADDR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == (ADDR_W+1)'(DEPTH));
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;
  assign empty_o  = empty_q;
  assign full_o   = full_q;

endmodule

// File: rtl/usb_buffer_arbiter.sv
// Arbiter for the shared single-port USB data buffer SRAM.
// Serialises RX stores, TX fetches and AHB reads/writes.
module usb_buffer_arbiter
  import usb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              rx_store,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              tx_get,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_data_valid,
  input  logic              ahb_wr_req,
  input  logic [DATA_W-1:0] ahb_wr_data,
  output logic              ahb_wr_ack,
  input  logic              ahb_rd_req,
  output logic [DATA_W-1:0] ahb_rd_data,
  output logic              ahb_rd_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W:0]   buffer_occupancy,
  output logic              buffer_empty,
  output logic              buffer_full,
  output logic              rx_overrun
);

  arb_state_e        state_q;
  sel_e              sel_q;
  logic [DATA_W-1:0] rx_hold_q;
  logic              rx_pend_q, flush_pend_q;
  logic              rx_overrun_q, last_ahb_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_wen_q, mem_ren_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              wr_ack_q, tx_vld_q, rd_vld_q;
  logic [DATA_W-1:0] tx_data_q, rd_data_q;

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              empty, full;
  logic              ahb_wr_ok, ahb_rd_ok, pick_wr;

  usb_fifo_ptrs u_ptrs (
    .clk      (clk),
    .rst      (rst),
    .inc_wr_i (state_q == ST_WRITE),
    .inc_rd_i (state_q == ST_READ),
    .clear_i  (state_q == ST_FLUSH),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr),
    .count_o  (buffer_occupancy),
    .empty_o  (empty),
    .full_o   (full)
  );

  // last_ahb_q = 1 means the last AHB grant was a write
  always_comb begin
    ahb_wr_ok = ahb_wr_req && !full;
    ahb_rd_ok = ahb_rd_req && !empty;
    pick_wr   = ahb_wr_ok && (!ahb_rd_ok || !last_ahb_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= SRC_RX;
      rx_hold_q    <= '0;
      rx_pend_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      rx_overrun_q <= 1'b0;
      last_ahb_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wen_q    <= 1'b0;
      mem_ren_q    <= 1'b0;
      mem_wdata_q  <= '0;
      wr_ack_q     <= 1'b0;
      tx_vld_q     <= 1'b0;
      rd_vld_q     <= 1'b0;
      tx_data_q    <= '0;
      rd_data_q    <= '0;
    end else begin
      mem_wen_q <= 1'b0;
      mem_ren_q <= 1'b0;
      wr_ack_q  <= 1'b0;
      tx_vld_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
      if (tx_vld_q) tx_data_q <= mem_rdata;
      if (rd_vld_q) rd_data_q <= mem_rdata;

      unique case (state_q)
        ST_IDLE: begin
          if (flush_pend_q) begin
            state_q <= ST_FLUSH;
          end else if (rx_pend_q && !full) begin
            state_q     <= ST_WRITE;
            sel_q       <= SRC_RX;
            mem_wen_q   <= 1'b1;
            mem_addr_q  <= wr_ptr;
            mem_wdata_q <= rx_hold_q;
          end else if (rx_pend_q) begin
            rx_pend_q    <= 1'b0;
            rx_overrun_q <= 1'b1;
          end else if (tx_get && !empty) begin
            state_q    <= ST_READ;
            sel_q      <= DST_TX;
            mem_ren_q  <= 1'b1;
            mem_addr_q <= rd_ptr;
          end else if (pick_wr) begin
            state_q     <= ST_WRITE;
            sel_q       <= SRC_AHB;
            mem_wen_q   <= 1'b1;
            mem_addr_q  <= wr_ptr;
            mem_wdata_q <= ahb_wr_data;
            wr_ack_q    <= 1'b1;
            last_ahb_q  <= 1'b1;
          end else if (ahb_rd_ok) begin
            state_q    <= ST_READ;
            sel_q      <= DST_AHB;
            mem_ren_q  <= 1'b1;
            mem_addr_q <= rd_ptr;
            last_ahb_q <= 1'b0;
          end
        end
        ST_WRITE: begin
          state_q <= ST_IDLE;
          if (sel_q == SRC_RX) rx_pend_q <= 1'b0;
        end
        ST_READ: begin
          state_q <= ST_RDATA;
          if (sel_q == DST_TX) tx_vld_q <= 1'b1;
          else                 rd_vld_q <= 1'b1;
        end
        ST_RDATA: state_q <= ST_IDLE;
        ST_FLUSH: begin
          state_q      <= ST_IDLE;
          rx_pend_q    <= 1'b0;
          rx_overrun_q <= 1'b0;
          flush_pend_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase

      // New arrivals override the clears above; flush beats a same-cycle byte
      if (flush) begin
        flush_pend_q <= 1'b1;
      end else if (rx_store) begin
        if (rx_pend_q) begin
          rx_overrun_q <= 1'b1;
        end else begin
          rx_hold_q <= rx_data;
          rx_pend_q <= 1'b1;
        end
      end
    end
  end

  assign tx_data       = tx_vld_q ? mem_rdata : tx_data_q;
  assign ahb_rd_data   = rd_vld_q ? mem_rdata : rd_data_q;
  assign tx_data_valid = tx_vld_q;
  assign ahb_rd_valid  = rd_vld_q;
  assign ahb_wr_ack    = wr_ack_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wen       = mem_wen_q;
  assign mem_ren       = mem_ren_q;
  assign mem_wdata     = mem_wdata_q;
  assign buffer_empty  = empty;
  assign buffer_full   = full;
  assign rx_overrun    = rx_overrun_q;

endmodule

// File: tb/tb_usb_buffer_arbiter.sv
// Directed bench for usb_buffer_arbiter with a behavioural SRAM.
// Inputs change and outputs are sampled on the falling edge.
module tb_usb_buffer_arbiter;

  logic       clk = 1'b0;
  logic       rst, flush, rx_store, tx_get;
  logic       ahb_wr_req, ahb_rd_req;
  logic [7:0] rx_data, ahb_wr_data, mem_rdata;
  logic [7:0] tx_data, ahb_rd_data, mem_wdata;
  logic       tx_data_valid, ahb_wr_ack, ahb_rd_valid;
  logic [5:0] mem_addr;
  logic       mem_wen, mem_ren;
  logic [6:0] buffer_occupancy;
  logic       buffer_empty, buffer_full, rx_overrun;

  logic [7:0] sram [64];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wen) sram[mem_addr] <= mem_wdata;
    if (mem_ren) mem_rdata <= sram[mem_addr];
  end

  usb_buffer_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .rx_store         (rx_store),
    .rx_data          (rx_data),
    .tx_get           (tx_get),
    .tx_data          (tx_data),
    .tx_data_valid    (tx_data_valid),
    .ahb_wr_req       (ahb_wr_req),
    .ahb_wr_data      (ahb_wr_data),
    .ahb_wr_ack       (ahb_wr_ack),
    .ahb_rd_req       (ahb_rd_req),
    .ahb_rd_data      (ahb_rd_data),
    .ahb_rd_valid     (ahb_rd_valid),
    .mem_addr         (mem_addr),
    .mem_wen          (mem_wen),
    .mem_ren          (mem_ren),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .buffer_occupancy (buffer_occupancy),
    .buffer_empty     (buffer_empty),
    .buffer_full      (buffer_full),
    .rx_overrun       (rx_overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_rx(input logic [7:0] d, input logic [5:0] a);
    @(negedge clk);
    rx_store = 1'b1;
    rx_data  = d;
    @(negedge clk);
    rx_store = 1'b0;
    @(negedge clk);
    chk("rx write", 32'({mem_wen, mem_addr, mem_wdata}),
        32'({1'b1, a, d}));
  endtask

  task automatic wait_tx(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_data_valid && n < 8);
  endtask

  task automatic ahb_write(input logic [7:0] d, input logic [5:0] a);
    int n;
    ahb_wr_req  = 1'b1;
    ahb_wr_data = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ahb_wr_ack && n < 8);
    chk("ahb write", 32'({ahb_wr_ack, mem_wen, mem_addr, mem_wdata}),
        32'({2'b11, a, d}));
    ahb_wr_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] t1 [3];
    logic [9:0] ack_exp, rv_exp;
    logic       seen;
    int         n;
    t1      = '{8'hA1, 8'hB2, 8'hC3};
    ack_exp = 10'b0001000010;
    rv_exp  = 10'b1000010000;

    rst = 1'b1; flush = 1'b0; rx_store = 1'b0; tx_get = 1'b0;
    ahb_wr_req = 1'b0; ahb_rd_req = 1'b0;
    rx_data = '0; ahb_wr_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset occ/empty/full/ovr",
        32'({buffer_occupancy, buffer_empty, buffer_full, rx_overrun}),
        32'({7'd0, 3'b100}));
    chk("reset strobes",
        32'({mem_wen, mem_ren, tx_data_valid, ahb_wr_ack, ahb_rd_valid}),
        32'(0));
    chk("reset data", 32'({mem_addr, mem_wdata, tx_data, ahb_rd_data}),
        32'(0));

    for (int i = 0; i < 3; i++) begin
      do_rx(t1[i], 6'(i));
      repeat (6) @(negedge clk);
    end
    chk("occ after 3 rx", 32'(buffer_occupancy), 32'd3);

    tx_get = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_tx(n);
      chk("tx latency", 32'(n), (i == 0) ? 32'd2 : 32'd3);
      chk("tx data", 32'(tx_data), 32'(t1[i]));
    end
    tx_get = 1'b0;
    chk("drained", 32'({buffer_empty, buffer_occupancy}),
        32'({1'b1, 7'd0}));

    for (int i = 1; i <= 4; i++) do_rx(8'(i), 6'(i + 2));
    @(negedge clk);
    chk("occ before rr", 32'(buffer_occupancy), 32'd4);
    ahb_wr_req  = 1'b1;
    ahb_wr_data = 8'h70;
    ahb_rd_req  = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("rr ack/valid", 32'({ahb_wr_ack, ahb_rd_valid}),
          32'({ack_exp[k], rv_exp[k]}));
      if (k == 1) begin
        chk("rr wr1", 32'({mem_addr, mem_wdata}), 32'({6'd7, 8'h70}));
        ahb_wr_data = 8'h71;
      end
      if (k == 4) chk("rr rd1", 32'(ahb_rd_data), 32'h01);
      if (k == 6) chk("rr wr2", 32'({mem_addr, mem_wdata}),
                      32'({6'd8, 8'h71}));
      if (k == 9) chk("rr rd2", 32'(ahb_rd_data), 32'h02);
    end
    ahb_wr_req = 1'b0;
    ahb_rd_req = 1'b0;
    chk("occ after rr", 32'(buffer_occupancy), 32'd4);

    @(negedge clk);
    do_flush();
    chk("flush 1", 32'({buffer_occupancy, buffer_empty}),
        32'({7'd0, 1'b1}));

    for (int i = 0; i < 64; i++) ahb_write(8'(i), 6'(i));
    chk("full", 32'({buffer_full, buffer_occupancy}), 32'({1'b1, 7'd64}));

    ahb_wr_req  = 1'b1;
    ahb_wr_data = 8'hEE;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= ahb_wr_ack;
    end
    chk("no ack while full", 32'(seen), 32'd0);
    tx_get = 1'b1;
    wait_tx(n);
    chk("tx while full", 32'({n[7:0], tx_data}), 32'({8'd2, 8'h00}));
    tx_get = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ahb_wr_ack && n < 8);
    chk("65th write wraps", 32'({n[7:0], mem_addr, mem_wdata}),
        32'({8'd2, 6'd0, 8'hEE}));
    ahb_wr_req = 1'b0;
    @(negedge clk);
    chk("full again", 32'({buffer_full, buffer_occupancy}),
        32'({1'b1, 7'd64}));

    rx_store = 1'b1;
    rx_data  = 8'h55;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      rx_store = 1'b0;
      seen |= mem_wen;
    end
    chk("overrun", 32'({seen, rx_overrun, buffer_occupancy}),
        32'({2'b01, 7'd64}));
    do_flush();
    chk("flush 2", 32'({buffer_occupancy, buffer_empty, rx_overrun}),
        32'({7'd0, 2'b10}));

    do_rx(8'h11, 6'd0);
    do_rx(8'h22, 6'd1);
    do_rx(8'h33, 6'd2);
    @(negedge clk);
    tx_get = 1'b1;
    wait_tx(n);
    chk("tx 11", 32'({n[7:0], tx_data}), 32'({8'd2, 8'h11}));
    chk("occ 2", 32'(buffer_occupancy), 32'd2);
    rx_store = 1'b1;
    rx_data  = 8'h44;
    @(negedge clk);
    rx_store = 1'b0;
    chk("idle no wen", 32'({mem_wen, mem_ren}), 32'd0);
    @(negedge clk);
    chk("rx first", 32'({mem_wen, mem_addr, mem_wdata}),
        32'({1'b1, 6'd3, 8'h44}));
    @(negedge clk);
    chk("occ 3", 32'(buffer_occupancy), 32'd3);
    wait_tx(n);
    chk("tx 22", 32'({n[7:0], tx_data}), 32'({8'd2, 8'h22}));
    chk("occ back 2", 32'(buffer_occupancy), 32'd2);
    tx_get = 1'b0;

    @(negedge clk);
    tx_get = 1'b1;
    @(negedge clk);
    chk("read cycle", 32'({mem_ren, mem_addr}), 32'({1'b1, 6'd2}));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("rdata after flush", 32'({tx_data_valid, tx_data}),
        32'({1'b1, 8'h33}));
    tx_get = 1'b0;
    @(negedge clk);
    chk("occ before flush", 32'(buffer_occupancy), 32'd1);
    @(negedge clk);
    chk("occ in flush", 32'(buffer_occupancy), 32'd1);
    @(negedge clk);
    chk("flushed", 32'({buffer_occupancy, buffer_empty}),
        32'({7'd0, 1'b1}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
